// File: rtl/seven_seg_scanner.sv
// Scans a 32-bit hex count onto a common-anode 7-segment array, one snapshot per frame.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int NUM_DIGITS  = 8
) (
  input  logic        clk_scan,
  input  logic        reset_scan,
  input  logic        enable_scan,
  input  logic [31:0] count_in,
  output logic [7:0]  an_out,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic        frame_tick
);

  localparam int              DIV_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [2:0]      DIGIT_LAST = 3'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [2:0]       digit_idx_reg, digit_idx_next;
  logic [31:0]      snap_reg, snap_next;
  logic [7:0]       an_reg, an_next;
  logic [6:0]       seg_reg, seg_next;
  logic             frame_tick_reg, frame_tick_next;
  logic             slot_tick;
  logic             frame_end;
  logic [3:0]       nibble;
  logic [7:0]       lit_mask;

  function automatic logic [6:0] hex7(input logic [3:0] value);
    logic [6:0] segs;
    case (value)
      4'h0:    segs = 7'b1000000;
      4'h1:    segs = 7'b1111001;
      4'h2:    segs = 7'b0100100;
      4'h3:    segs = 7'b0110000;
      4'h4:    segs = 7'b0011001;
      4'h5:    segs = 7'b0010010;
      4'h6:    segs = 7'b0000010;
      4'h7:    segs = 7'b1111000;
      4'h8:    segs = 7'b0000000;
      4'h9:    segs = 7'b0010000;
      4'hA:    segs = 7'b0001000;
      4'hB:    segs = 7'b0000011;
      4'hC:    segs = 7'b1000110;
      4'hD:    segs = 7'b0100001;
      4'hE:    segs = 7'b0000110;
      default: segs = 7'b0001110;
    endcase
    return segs;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // A digit stays lit only if it or some higher nibble of the snapshot is nonzero.
  logic [7:0] nz;
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lit
      assign nz[gi] = |snap_reg[4*gi +: 4];
      if (gi == 0) begin : g_first
        assign lit_mask[gi] = 1'b1;
      end else begin : g_upper
        assign lit_mask[gi] = |nz[7:gi];
      end
    end
  endgenerate
`else
  assign lit_mask = 8'hFF;
`endif

  always_comb begin
    slot_tick       = (div_cnt_reg == DIV_LAST);
    frame_end       = slot_tick && (digit_idx_reg == DIGIT_LAST);
    nibble          = snap_reg[{digit_idx_reg, 2'b00} +: 4];
    div_cnt_next    = div_cnt_reg;
    digit_idx_next  = digit_idx_reg;
    snap_next       = snap_reg;
    frame_tick_next = 1'b0;
    an_next         = 8'hFF;
    seg_next        = 7'h7F;
    if (enable_scan) begin
      div_cnt_next = slot_tick ? '0 : div_cnt_reg + 1'b1;
      if (slot_tick) begin
        digit_idx_next = (digit_idx_reg == DIGIT_LAST) ? 3'd0 : digit_idx_reg + 3'd1;
      end
      // The frame snapshot is taken on the same edge the last digit slot ends.
      if (frame_end) begin
        snap_next = count_in;
      end
      frame_tick_next = frame_end;
      an_next         = lit_mask[digit_idx_reg] ? ~(8'd1 << digit_idx_reg) : 8'hFF;
      seg_next        = hex7(nibble);
    end
  end

  always_ff @(posedge clk_scan) begin
    if (reset_scan) begin
      div_cnt_reg    <= '0;
      digit_idx_reg  <= 3'd0;
      snap_reg       <= 32'h0;
      an_reg         <= 8'hFF;
      seg_reg        <= 7'h7F;
      frame_tick_reg <= 1'b0;
    end else begin
      div_cnt_reg    <= div_cnt_next;
      digit_idx_reg  <= digit_idx_next;
      snap_reg       <= snap_next;
      an_reg         <= an_next;
      seg_reg        <= seg_next;
      frame_tick_reg <= frame_tick_next;
    end
  end

  assign an_out     = an_reg;
  assign seg_out    = seg_reg;
  assign dp_out     = 1'b1;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: vector table, directed frame sequences and a
// randomized run against a slot-position reference model.
module tb_seven_seg_scanner;

  localparam int RD    = 4;
  localparam int ND    = 8;
  localparam int FRAME = RD * ND;

  logic        clk_scan    = 1'b0;
  logic        reset_scan  = 1'b1;
  logic        enable_scan = 1'b1;
  logic [31:0] count_in    = 32'h1234ABCD;
  logic [7:0]  an_out;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic        frame_tick;

  always #5 clk_scan = ~clk_scan;

  seven_seg_scanner #(.REFRESH_DIV(RD), .NUM_DIGITS(ND)) dut (
    .clk_scan   (clk_scan),
    .reset_scan (reset_scan),
    .enable_scan(enable_scan),
    .count_in   (count_in),
    .an_out     (an_out),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .frame_tick (frame_tick)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] an;
    logic [6:0] seg;
    logic       ft;
  } vec_t;

  vec_t       vecs [9];
  logic [6:0] hex_tab [16];
  logic [7:0] scan_an [8];
  logic [6:0] scan_seg [8];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_pos    = 0;
  logic [31:0] m_snap   = 32'h0;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_ft;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the display position within a frame is just a count of enabled cycles since reset.
  task automatic model_step();
    int         d;
    bit         lit;
    logic [3:0] nib;
    if (reset_scan) begin
      m_pos = 0; m_snap = 32'h0;
      e_an = 8'hFF; e_seg = 7'h7F; e_ft = 1'b0;
    end else if (!enable_scan) begin
      e_an = 8'hFF; e_seg = 7'h7F; e_ft = 1'b0;
    end else begin
      d   = m_pos / RD;
      nib = m_snap[4*d +: 4];
      lit = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      lit = (d == 0) || ((m_snap >> (4*d)) != 0);
`endif
      e_an  = lit ? ~(8'd1 << d) : 8'hFF;
      e_seg = hex_tab[nib];
      e_ft  = (m_pos == FRAME - 1);
      if (e_ft) m_snap = count_in;
      m_pos = (m_pos + 1) % FRAME;
    end
  endtask

  task automatic tick(input bit chk);
    model_step();
    @(posedge clk_scan);
    #1;
    if (chk) begin
      check("an_out", an_out, e_an);
      check("seg_out", seg_out, e_seg);
      check("dp_out", dp_out, 1'b1);
      check("frame_tick", frame_tick, e_ft);
    end
  endtask

  task automatic wait_frame(input int lim, output int n);
    n = 0;
    do begin
      tick(1'b1);
      n++;
    end while (frame_tick !== 1'b1 && n < lim);
    check("frame_wait", frame_tick, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int guard;
    int lit_cycles;
    hex_tab  = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    scan_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    scan_seg = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
    vecs[0] = '{1'b1, 1'b1, 8'hFF, 7'h7F, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'hFF, 7'h7F, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 8'hFF, 7'h7F, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'hFE, 7'h40, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'hFE, 7'h40, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'hFF, 7'h7F, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 8'hFF, 7'h7F, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 8'hFE, 7'h40, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 8'hFE, 7'h40, 1'b0};

    // Reset, release and a short enable gap from the very first slot.
    for (int i = 0; i < 9; i++) begin
      reset_scan  = vecs[i].rst;
      enable_scan = vecs[i].en;
      tick(1'b0);
      check("vec_an", an_out, vecs[i].an);
      check("vec_seg", seg_out, vecs[i].seg);
      check("vec_ft", frame_tick, vecs[i].ft);
      $display("vec %0d: rst=%0b en=%0b an=%h seg=%b ft=%b", i, vecs[i].rst, vecs[i].en,
               an_out, seg_out, frame_tick);
    end

    // Full scan and frame period with a held count.
    reset_scan = 1'b0; enable_scan = 1'b1; count_in = 32'h1234ABCD;
    wait_frame(80, n);
    wait_frame(80, n);
    check("frame_period", n, FRAME);
    $display("full scan: frame period %0d cycles", n);

    // Drop enable for 10 cycles inside the digit-2 slot.
    for (int i = 0; i < 9; i++) tick(1'b1);
    enable_scan = 1'b0;
    for (int i = 0; i < 10; i++) tick(1'b1);
    enable_scan = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      check("gate_resume_an", an_out, 8'hFB);
    end
    tick(1'b1);
    check("gate_next_an", an_out, 8'hF7);
    $display("enable gating: resumed digit 2, then an=%h", an_out);

    // Explicit frame walk; count_in changes inside the digit-3 slot.
    wait_frame(80, n);
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < RD; c++) begin
        tick(1'b1);
        check("scan_an", an_out, scan_an[s]);
        check("scan_seg", seg_out, scan_seg[s]);
        if (s == 3 && c == 0) count_in = 32'h00000005;
      end
    end
    check("coherent_ft", frame_tick, 1'b1);
    tick(1'b1);
    check("coherent_new_an", an_out, 8'hFE);
    check("coherent_new_seg", seg_out, 7'b0010010);
    $display("coherence: new digit0 an=%h seg=%b", an_out, seg_out);

    // Reset in the middle of the digit-5 slot.
    guard = 0;
    while (m_pos / RD != 5 && guard < 2 * FRAME) begin
      tick(1'b1);
      guard++;
    end
    tick(1'b1);
    reset_scan = 1'b1;
    tick(1'b1);
    check("midreset_an", an_out, 8'hFF);
    check("midreset_seg", seg_out, 7'h7F);
    check("midreset_ft", frame_tick, 1'b0);
    reset_scan = 1'b0;
    tick(1'b1);
    check("postreset_an", an_out, 8'hFE);
    check("postreset_seg", seg_out, 7'h40);
    $display("mid-frame reset: restart an=%h seg=%b", an_out, seg_out);

    // Randomized enable/reset/count traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset_scan  = ($urandom_range(0, 199) == 0);
      enable_scan = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) count_in = $urandom >> (4 * $urandom_range(0, 7));
      tick(1'b1);
    end
    $display("random: 3000 cycles applied");

`ifdef LEADING_ZERO_BLANK_EN
    reset_scan = 1'b1; enable_scan = 1'b1;
    tick(1'b1);
    reset_scan = 1'b0; count_in = 32'h000000A5;
    wait_frame(80, n);
    lit_cycles = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b1);
      if (an_out != 8'hFF) lit_cycles++;
    end
    check("lzb_a5_lit_cycles", lit_cycles, 2 * RD);
    count_in = 32'h0;
    wait_frame(80, n);
    lit_cycles = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick(1'b1);
      if (an_out != 8'hFF) lit_cycles++;
    end
    check("lzb_zero_lit_cycles", lit_cycles, RD);
    $display("leading zero blank: zero shows %0d lit cycles", lit_cycles);
`else
    lit_cycles = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Reader side of the 32-bit count bus driven by the team's lab counter block.
- Samples the count once per display frame and shows it as 8 hex digits on the board's common-anode 7-segment array.
- Time-multiplexes the digits with a programmable refresh prescaler.
- Sits between the counter output and the top-level anode/cathode pins.

Parameters:
- REFRESH_DIV, 100000, clocks per digit slot; legal range 1 and up. At 100 MHz the default gives 1 kHz per digit.
- NUM_DIGITS, 8, number of digits scanned; legal range 1..8. Digit k shows count_in[4k+3:4k].

Ports:
- clk_scan  in  1  system clock, rising edge.
- reset_scan  in  1  synchronous, active-high reset.
- enable_scan  in  1  1 = scan and display; 0 = freeze the scan and blank the display.
- count_in  in  32  count value to display; hex-coded, unsigned.
- an_out  out  8  digit anodes, active-low; bit k selects digit k; bits at NUM_DIGITS and above are held at 1.
- seg_out  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp_out  out  1  decimal point, active-low; held at 1 (off).
- frame_tick  out  1  one-cycle pulse marking a new frame and snapshot.

Behaviour:
- Reset (sampled only on a clk_scan edge) clears all state:
  - div_cnt=0, digit_idx=0, snap=32'h0.
  - an_out=8'hFF, seg_out=7'h7F, dp_out=1, frame_tick=0.
  - Reset overrides enable_scan and is honoured mid-frame.
- Prescaler: div_cnt counts 0..REFRESH_DIV-1 and wraps to 0. slot_tick = (div_cnt==REFRESH_DIV-1). With REFRESH_DIV=1, slot_tick is asserted every cycle.
- Digit index: on slot_tick, digit_idx advances; NUM_DIGITS-1 wraps to 0.
- Snapshot: on the edge where slot_tick=1 and digit_idx==NUM_DIGITS-1:
  - snap <= count_in.
  - frame_tick <= 1 for exactly one cycle.
  - Otherwise frame_tick <= 0.
  - count_in changes mid-frame are never displayed until the next snapshot, so every frame is coherent.
  - Until the first snapshot after reset, the display shows all zeros.
- Output stage is registered: an_out and seg_out reflect the digit_idx/snap values from the previous cycle (1-cycle latency).
  - an_out = ~(1<<digit_idx).
  - seg_out = hex7(snap nibble digit_idx).
- hex7 encoding, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- enable_scan=0:
  - div_cnt, digit_idx and snap hold their values; no frame_tick is generated.
  - From the next edge: an_out=8'hFF, seg_out=7'h7F.
  - On re-enable, scanning resumes from the held div_cnt/digit_idx with no skipped or repeated digit.
- Both enable and reset are sampled synchronously; there are no asynchronous paths.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Any digit k>0 whose position is above the most significant nonzero nibble of snap has its anode forced to 1 during its slot.
  - Digit 0 is always lit, so snap=0 shows a single "0".
  - The blanking decision uses snap only; timing and slot lengths are unchanged.
- Undefined: all NUM_DIGITS digits are lit, including leading zeros.

Test Plan:
- All scenarios use REFRESH_DIV=4, NUM_DIGITS=8 and enable_scan=1 unless stated.
- Reset: hold reset_scan for 3 cycles -> an_out=8'hFF, seg_out=7'h7F, frame_tick=0. The first cycle after release gives an_out=8'hFE, seg_out=7'b1000000.
- Full scan: count_in=32'h1234ABCD held.
  - After frame_tick, an_out steps FE,FD,FB,F7,EF,DF,BF,7F, each for 4 cycles.
  - seg_out shows d,C,b,A,4,3,2,1.
  - frame_tick recurs every 32 cycles.
- Coherence: change count_in to 32'h00000005 during the digit-3 slot -> the remaining digits still show the old value. The new value appears only after the next frame_tick; digit 0 then shows 0010010.
- Enable gating: drop enable_scan for 10 cycles during the digit-2 slot.
  - an_out=8'hFF and no frame_tick during the gap.
  - On re-enable, digit 2 completes its remaining slot cycles.
- Mid-frame reset: assert reset_scan during the digit-5 slot -> the next edge gives all reset values. The scan restarts at digit 0 with snap=0.
- With LEADING_ZERO_BLANK_EN: count_in=32'h000000A5 -> only an_out FE and FD assert, showing 5 and A. count_in=0 -> only digit 0 lit, showing "0".
